// File: rtl/branch_ctrl.sv
// rtl/branch_ctrl.sv - EX-stage branch resolution, mispredict redirect and pipeline flush control
//
// Purpose: resolves branches and jumps from the comparator flags, checks the
// result against the fetch prediction, and on a mispredict pulses a PC
// redirect followed by a FLUSH_CYCLES-long pipeline flush. New branches are
// refused until the flush finishes.
//
// Parameters:
//   FLUSH_CYCLES     cycles o_flush is held after a mispredict (1..15)
// Optional build macro:
//   BRCTRL_PERF_EN   builds the branch / mispredict performance counters;
//                    when undefined both counter outputs are tied to 0
//
// Ports:
//   i_clk, i_rst_n          clock, asynchronous active-low reset
//   i_br_valid              branch/jump present in EX
//   i_br_funct3, i_is_jump  decoded branch type
//   i_pred_taken            fetch-stage prediction
//   i_br_target, i_pc_plus4 taken target and fall-through PC
//   i_stall                 EX held by a hazard, branch not accepted
//   i_br_less, i_br_equal   comparator flags
//   o_br_unsigned           comparator select (combinational)
//   o_ready                 idle, can accept a branch
//   o_redirect, o_redirect_pc  one-cycle fetch redirect and corrected PC
//   o_flush                 squash IF/ID/EX
//   o_illegal               reserved funct3 accepted (one-cycle pulse)
//   o_br_count, o_mispred_count  performance counters
module branch_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_br_valid,
  input  logic [2:0]  i_br_funct3,
  input  logic        i_is_jump,
  input  logic        i_pred_taken,
  input  logic [31:0] i_br_target,
  input  logic [31:0] i_pc_plus4,
  input  logic        i_stall,
  input  logic        i_br_less,
  input  logic        i_br_equal,
  output logic        o_br_unsigned,
  output logic        o_ready,
  output logic        o_redirect,
  output logic [31:0] o_redirect_pc,
  output logic        o_flush,
  output logic        o_illegal,
  output logic [31:0] o_br_count,
  output logic [31:0] o_mispred_count
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'b00,
    S_REDIRECT = 2'b01,
    S_FLUSH    = 2'b10
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        ready_q, ready_d;
  logic        redirect_q, redirect_d;
  logic        flush_q, flush_d;
  logic        illegal_q, illegal_d;
  logic [31:0] rpc_q, rpc_d;

  logic accept;
  logic taken;
  logic reserved;
  logic mispred;

  // Unsigned compare is selected by funct3[1] for BLTU/BGEU; the select is
  // driven even without a valid branch so the comparator settles early.
  assign o_br_unsigned = i_br_funct3[1];

  // ready_q is high only in IDLE, so accept implies the FSM is idle.
  assign accept = i_br_valid & ready_q & ~i_stall;

  always_comb begin
    taken    = 1'b0;
    reserved = 1'b0;
    if (i_is_jump) begin
      taken = 1'b1;
    end else begin
      case (i_br_funct3)
        3'b000:          taken = i_br_equal;
        3'b001:          taken = ~i_br_equal;
        3'b100, 3'b110:  taken = i_br_less;
        3'b101, 3'b111:  taken = ~i_br_less;
        default: begin
          taken    = 1'b0;
          reserved = 1'b1;
        end
      endcase
    end
  end

  assign mispred = taken ^ i_pred_taken;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rpc_d     = rpc_q;
    illegal_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          rpc_d     = taken ? i_br_target : i_pc_plus4;
          illegal_d = reserved;
          if (mispred) state_d = S_REDIRECT;
        end
      end
      S_REDIRECT: begin
        // The redirect cycle itself is the first flush cycle.
        cnt_d   = 4'(FLUSH_CYCLES - 1);
        state_d = (FLUSH_CYCLES == 1) ? S_IDLE : S_FLUSH;
      end
      S_FLUSH: begin
        cnt_d = (cnt_q == 4'd0) ? 4'd0 : cnt_q - 4'd1;
        if (cnt_q <= 4'd1) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
    // Outputs are decoded from the next state so they come straight from flops.
    ready_d    = (state_d == S_IDLE);
    redirect_d = (state_d == S_REDIRECT);
    flush_d    = (state_d != S_IDLE);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= 4'd0;
      ready_q    <= 1'b1;
      redirect_q <= 1'b0;
      flush_q    <= 1'b0;
      illegal_q  <= 1'b0;
      rpc_q      <= 32'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ready_q    <= ready_d;
      redirect_q <= redirect_d;
      flush_q    <= flush_d;
      illegal_q  <= illegal_d;
      rpc_q      <= rpc_d;
    end
  end

  assign o_ready       = ready_q;
  assign o_redirect    = redirect_q;
  assign o_redirect_pc = rpc_q;
  assign o_flush       = flush_q;
  assign o_illegal     = illegal_q;

`ifdef BRCTRL_PERF_EN
  logic [31:0] br_cnt_q;
  logic [31:0] mis_cnt_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      br_cnt_q  <= 32'd0;
      mis_cnt_q <= 32'd0;
    end else if (accept) begin
      br_cnt_q <= br_cnt_q + 32'd1;
      if (mispred) mis_cnt_q <= mis_cnt_q + 32'd1;
    end
  end

  assign o_br_count      = br_cnt_q;
  assign o_mispred_count = mis_cnt_q;
`else
  assign o_br_count      = 32'd0;
  assign o_mispred_count = 32'd0;
`endif

endmodule

// File: tb/tb_branch_ctrl.sv
// tb/tb_branch_ctrl.sv - directed self-checking bench for branch_ctrl with a redirect scoreboard
module tb_branch_ctrl;

`ifdef BRCTRL_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        br_valid;
  logic [2:0]  br_funct3;
  logic        is_jump;
  logic        pred_taken;
  logic [31:0] br_target;
  logic [31:0] pc_plus4;
  logic        stall;
  logic        br_less;
  logic        br_equal;
  logic        br_unsigned;
  logic        ready;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        flush;
  logic        illegal;
  logic [31:0] br_count;
  logic [31:0] mispred_count;

  typedef struct {
    bit          mis;
    logic [31:0] pc;
    bit          ill;
  } exp_t;

  exp_t sb_q[$];
  int   tests = 0;
  int   fails = 0;
  int   exp_br = 0;
  int   exp_mis = 0;

  branch_ctrl #(.FLUSH_CYCLES(2)) u_dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .i_br_valid      (br_valid),
    .i_br_funct3     (br_funct3),
    .i_is_jump       (is_jump),
    .i_pred_taken    (pred_taken),
    .i_br_target     (br_target),
    .i_pc_plus4      (pc_plus4),
    .i_stall         (stall),
    .i_br_less       (br_less),
    .i_br_equal      (br_equal),
    .o_br_unsigned   (br_unsigned),
    .o_ready         (ready),
    .o_redirect      (redirect),
    .o_redirect_pc   (redirect_pc),
    .o_flush         (flush),
    .o_illegal       (illegal),
    .o_br_count      (br_count),
    .o_mispred_count (mispred_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_br(logic [2:0] f3, logic jump, logic pred, logic less, logic eq,
                        logic [31:0] tgt, logic [31:0] pc4);
    br_valid   = 1'b1;
    br_funct3  = f3;
    is_jump    = jump;
    pred_taken = pred;
    br_less    = less;
    br_equal   = eq;
    br_target  = tgt;
    pc_plus4   = pc4;
  endtask

  task automatic push_exp(bit mis, logic [31:0] pc, bit ill);
    exp_t e;
    e.mis = mis;
    e.pc  = pc;
    e.ill = ill;
    sb_q.push_back(e);
    exp_br++;
    if (mis) exp_mis++;
  endtask

  // Called one cycle after an accepting edge, when the redirect/illegal outputs are due.
  task automatic check_sb(string tag);
    exp_t e;
    tests++;
    if (sb_q.size() == 0) begin
      fails++;
      $display("FAIL %s_sb observed=empty expected=entry", tag);
    end else begin
      e = sb_q.pop_front();
      check({tag, "_redirect"}, 32'(redirect), 32'(e.mis));
      check({tag, "_illegal"},  32'(illegal),  32'(e.ill));
      if (e.mis) check({tag, "_pc"}, redirect_pc, e.pc);
    end
  endtask

  task automatic check_counts(string tag);
    check({tag, "_br_count"},  br_count,      PERF ? 32'(exp_br)  : 32'd0);
    check({tag, "_mis_count"}, mispred_count, PERF ? 32'(exp_mis) : 32'd0);
  endtask

  task automatic check_ctl(string tag, logic rdy, logic rd, logic fl);
    check({tag, "_ready"},    32'(ready),    32'(rdy));
    check({tag, "_redirect"}, 32'(redirect), 32'(rd));
    check({tag, "_flush"},    32'(flush),    32'(fl));
  endtask

  initial begin
    rst_n = 1'b0;
    br_valid = 1'b0; br_funct3 = 3'b000; is_jump = 1'b0; pred_taken = 1'b0;
    br_target = 32'd0; pc_plus4 = 32'd0; stall = 1'b0; br_less = 1'b0; br_equal = 1'b0;
    tick();
    tick();
    check_ctl("rst", 1'b1, 1'b0, 1'b0);
    check("rst_pc", redirect_pc, 32'd0);
    check("rst_illegal", 32'(illegal), 32'd0);
    check_counts("rst");
    br_funct3 = 3'b110;
    #1;
    check("unsigned_110_novalid", 32'(br_unsigned), 32'd1);
    br_funct3 = 3'b000;
    #1;
    check("unsigned_000", 32'(br_unsigned), 32'd0);
    rst_n = 1'b1;
    tick();

    // BEQ taken, predicted not taken: redirect to target, flush two cycles.
    set_br(3'b000, 1'b0, 1'b0, 1'b0, 1'b1, 32'h100, 32'h0C4);
    push_exp(1'b1, 32'h100, 1'b0);
    tick();
    br_valid = 1'b0;
    check_sb("beq");
    check_ctl("beq_t1", 1'b0, 1'b1, 1'b1);
    tick();
    check_ctl("beq_t2", 1'b0, 1'b0, 1'b1);
    tick();
    check_ctl("beq_t3", 1'b1, 1'b0, 1'b0);
    check_counts("beq");

    // BLTU correctly predicted taken, then BNE back-to-back.
    set_br(3'b110, 1'b0, 1'b1, 1'b1, 1'b0, 32'h180, 32'h0D0);
    #1;
    check("bltu_unsigned", 32'(br_unsigned), 32'd1);
    push_exp(1'b0, 32'h180, 1'b0);
    tick();
    check_sb("bltu");
    check_ctl("bltu_t1", 1'b1, 1'b0, 1'b0);
    set_br(3'b001, 1'b0, 1'b1, 1'b0, 1'b0, 32'h1C0, 32'h0D4);
    push_exp(1'b0, 32'h1C0, 1'b0);
    tick();
    br_valid = 1'b0;
    check_sb("bne_b2b");
    check_ctl("bne_t1", 1'b1, 1'b0, 1'b0);
    check_counts("b2b");

    // BGE not taken but predicted taken; a valid during flush is dropped.
    set_br(3'b101, 1'b0, 1'b1, 1'b1, 1'b0, 32'h280, 32'h204);
    #1;
    check("bge_unsigned", 32'(br_unsigned), 32'd0);
    push_exp(1'b1, 32'h204, 1'b0);
    tick();
    check_sb("bge");
    set_br(3'b000, 1'b0, 1'b0, 1'b0, 1'b1, 32'h900, 32'h904);
    tick();
    check_ctl("bge_t2_ignored", 1'b0, 1'b0, 1'b1);
    br_valid = 1'b0;
    tick();
    check_ctl("bge_t3", 1'b1, 1'b0, 1'b0);
    check_counts("bge_ignored");

    // Reserved funct3: illegal pulse, treated as not taken.
    set_br(3'b011, 1'b0, 1'b1, 1'b1, 1'b1, 32'h300, 32'h404);
    push_exp(1'b1, 32'h404, 1'b1);
    tick();
    br_valid = 1'b0;
    check_sb("rsvd");
    tick();
    check("rsvd_illegal_t2", 32'(illegal), 32'd0);
    tick();
    check_ctl("rsvd_t3", 1'b1, 1'b0, 1'b0);

    // JAL predicted not taken: jump ignores funct3 and flags, no illegal.
    set_br(3'b010, 1'b1, 1'b0, 1'b0, 1'b0, 32'h480, 32'h488);
    push_exp(1'b1, 32'h480, 1'b0);
    tick();
    br_valid = 1'b0;
    check_sb("jal");
    tick();
    tick();
    check_counts("jal");

    // Stall for three edges, accept on the first unstalled edge.
    set_br(3'b000, 1'b0, 1'b0, 1'b0, 1'b1, 32'h500, 32'h504);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_ctl("stall", 1'b1, 1'b0, 1'b0);
    end
    check_counts("stall");
    stall = 1'b0;
    push_exp(1'b1, 32'h500, 1'b0);
    tick();
    br_valid = 1'b0;
    check_sb("unstall");
    check_counts("unstall");
    tick();
    tick();
    check_ctl("unstall_t3", 1'b1, 1'b0, 1'b0);

    // Asynchronous reset in the middle of redirect/flush.
    set_br(3'b001, 1'b0, 1'b0, 1'b0, 1'b0, 32'h580, 32'h584);
    push_exp(1'b1, 32'h580, 1'b0);
    tick();
    br_valid = 1'b0;
    check_sb("pre_rst");
    #2;
    rst_n = 1'b0;
    #1;
    check_ctl("async_rst", 1'b1, 1'b0, 1'b0);
    exp_br = 0;
    exp_mis = 0;
    check_counts("async_rst");
    tick();
    rst_n = 1'b1;
    tick();
    check_ctl("post_rst", 1'b1, 1'b0, 1'b0);
    set_br(3'b001, 1'b0, 1'b0, 1'b0, 1'b0, 32'h600, 32'h604);
    push_exp(1'b1, 32'h600, 1'b0);
    tick();
    br_valid = 1'b0;
    check_sb("post_rst_br");
    check_ctl("post_rst_t1", 1'b0, 1'b1, 1'b1);
    tick();
    tick();
    check_ctl("post_rst_t3", 1'b1, 1'b0, 1'b0);
    check_counts("post_rst");

    check("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
